// File: rtl/button_debounce_snapshot_if.sv
// button_debounce_snapshot_if: snapshot handshake between the debouncer and the serializer
interface button_debounce_snapshot_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] snapshot_data;
  logic             snapshot_valid;
  logic             snapshot_ready;
  logic [7:0]       snapshot_seq;
  modport master (output snapshot_data, snapshot_valid, snapshot_seq, input snapshot_ready);
  modport slave (input snapshot_data, snapshot_valid, snapshot_seq, output snapshot_ready);
endinterface

// File: rtl/button_debounce_snapshot.sv
// button_debounce_snapshot: synchronize and debounce a button word, offer changes (and optional heartbeats) downstream
module button_debounce_snapshot #(
  parameter int WIDTH            = 32,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int HEARTBEAT_CYCLES = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           button_array,
  button_debounce_snapshot_if.master snap
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = HEARTBEAT_CYCLES > 1 ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_CYCLES > 0 ? HEARTBEAT_CYCLES - 1 : 0);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [HW-1:0]    hb_q, hb_d;
  logic [7:0]       seq_q, seq_d;
  logic             capture;
  // a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing clocks
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    seq_d   = seq_q;
    hb_d    = hb_q;
    capture = 1'b0;
    if (state_q == IDLE) begin
      capture = (stable_q != last_q) || (HEARTBEAT_CYCLES != 0 && hb_q == HB_LAST);
      hb_d    = capture ? '0 : hb_q + 1'b1;
      state_d = capture ? OFFER : IDLE;
      data_d  = capture ? stable_q : data_q;
    end else if (snap.snapshot_ready) begin
      state_d = IDLE;
      last_d  = data_q;
      seq_d   = seq_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      last_q   <= '0;
      data_q   <= '0;
      hb_q     <= '0;
      seq_q    <= '0;
      state_q  <= IDLE;
    end else begin
      sync1_q  <= button_array;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      data_q   <= data_d;
      hb_q     <= hb_d;
      seq_q    <= seq_d;
      state_q  <= state_d;
    end
  end
  assign snap.snapshot_data  = data_q;
  assign snap.snapshot_valid = state_q == OFFER;
  assign snap.snapshot_seq   = seq_q;
endmodule

// File: tb/tb_button_debounce_snapshot.sv
// tb_button_debounce_snapshot: directed vector table plus hand sequences for backpressure, reset, heartbeat and seq wrap
module tb_button_debounce_snapshot;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        reset2_n = 1'b0;
  logic [31:0] btn = '0;
  logic [31:0] btn2 = '0;
  int          total = 0;
  int          bad = 0;
  int          n;
  int          cnt;
  button_debounce_snapshot_if #(.WIDTH(32)) s1 ();
  button_debounce_snapshot_if #(.WIDTH(32)) s2 ();
  button_debounce_snapshot #(.WIDTH(32), .DEBOUNCE_CYCLES(4), .HEARTBEAT_CYCLES(0)) dut (
    .clock(clock), .reset_n(reset_n), .button_array(btn), .snap(s1));
  button_debounce_snapshot #(.WIDTH(32), .DEBOUNCE_CYCLES(4), .HEARTBEAT_CYCLES(10)) dut_hb (
    .clock(clock), .reset_n(reset2_n), .button_array(btn2), .snap(s2));
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] btn;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  es;
  } vec_t;
  vec_t tbl [$];
  task automatic add(input logic [31:0] b, input logic r, input logic ev, input logic [31:0] ed,
                     input logic [7:0] es, input int rep);
    vec_t v;
    v.btn = b; v.rdy = r; v.ev = ev; v.ed = ed; v.es = es;
    repeat (rep) tbl.push_back(v);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic wait_valid(input bit hb, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(hb ? s2.snapshot_valid : s1.snapshot_valid) && k < 40);
  endtask
  initial begin
    s1.snapshot_ready = 1'b1;
    s2.snapshot_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, s1.snapshot_valid}, 0);
    chk("rst_data", s1.snapshot_data, 0);
    chk("rst_seq", {24'd0, s1.snapshot_seq}, 0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (s1.snapshot_valid) cnt++;
    end
    chk("idle_quiet", cnt, 0);
    // single press, 3-clock glitch, then a 4-clock pulse that just survives debouncing
    add(32'h1, 1, 0, 32'h0, 0, 6);
    add(32'h1, 1, 1, 32'h1, 0, 1);
    add(32'h1, 1, 0, 32'h1, 1, 2);
    add(32'h21, 1, 0, 32'h1, 1, 3);
    add(32'h1, 1, 0, 32'h1, 1, 8);
    add(32'h21, 1, 0, 32'h1, 1, 4);
    add(32'h1, 1, 0, 32'h1, 1, 2);
    add(32'h1, 1, 1, 32'h21, 1, 1);
    add(32'h1, 1, 0, 32'h21, 2, 3);
    add(32'h1, 1, 1, 32'h1, 2, 1);
    add(32'h1, 1, 0, 32'h1, 3, 2);
    foreach (tbl[i]) begin
      btn = tbl[i].btn;
      s1.snapshot_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, s1.snapshot_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_data", i), s1.snapshot_data, tbl[i].ed);
      chk($sformatf("vec%0d_seq", i), {24'd0, s1.snapshot_seq}, {24'd0, tbl[i].es});
    end
    s1.snapshot_ready = 1'b0;
    btn = 32'h0F;
    wait_valid(0, n);
    chk("bp_latency", n, 7);
    chk("bp_data", s1.snapshot_data, 32'h0F);
    btn = 32'hF0;
    cnt = 0;
    repeat (12) begin
      tick();
      if (!(s1.snapshot_valid && s1.snapshot_data == 32'h0F)) cnt++;
    end
    chk("bp_hold", cnt, 0);
    s1.snapshot_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", {31'd0, s1.snapshot_valid}, 0);
    chk("bp_xfer_seq", {24'd0, s1.snapshot_seq}, 4);
    tick();
    chk("bp_reoffer_valid", {31'd0, s1.snapshot_valid}, 1);
    chk("bp_reoffer_data", s1.snapshot_data, 32'hF0);
    tick();
    chk("bp_reoffer_seq", {24'd0, s1.snapshot_seq}, 5);
    s1.snapshot_ready = 1'b0;
    btn = 32'h1;
    wait_valid(0, n);
    chk("rs_offer_valid", {31'd0, s1.snapshot_valid}, 1);
    reset_n = 1'b0;
    tick();
    chk("rs_valid", {31'd0, s1.snapshot_valid}, 0);
    chk("rs_data", s1.snapshot_data, 0);
    chk("rs_seq", {24'd0, s1.snapshot_seq}, 0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (s1.snapshot_valid) cnt++;
    end
    chk("rs_early_valid", cnt, 0);
    tick();
    chk("rs_reoffer_valid", {31'd0, s1.snapshot_valid}, 1);
    chk("rs_reoffer_data", s1.snapshot_data, 32'h1);
    btn2 = 32'h12345678;
    tick();
    tick();
    reset2_n = 1'b1;
    wait_valid(1, n);
    chk("hb_first_valid", {31'd0, s2.snapshot_valid}, 1);
    chk("hb_first_data", s2.snapshot_data, 32'h12345678);
    chk("hb_first_seq", {24'd0, s2.snapshot_seq}, 0);
    for (int i = 1; i < 256; i++) begin
      wait_valid(1, n);
      chk("hb_gap", n, 11);
      chk("hb_data", s2.snapshot_data, 32'h12345678);
      chk("hb_seq", {24'd0, s2.snapshot_seq}, 32'(i));
    end
    tick();
    chk("seq_wrap", {24'd0, s2.snapshot_seq}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debounce_snapshot.md
BUTTON_DEBOUNCE_SNAPSHOT -- requirements
Module: button_debounce_snapshot

Interface
REQ-001 Parameter WIDTH, default 32: number of button inputs and snapshot bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive clocks a synchronized bit must differ from its stable value before the stable value is updated; legal range is 2 or more.
REQ-003 Parameter HEARTBEAT_CYCLES, default 0: number of idle clocks after which an unchanged snapshot is re-offered; 0 disables the heartbeat.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 button_array  input  WIDTH  raw asynchronous button levels, 1 = pressed.
REQ-007 snapshot_data  output  WIDTH  debounced button word offered downstream to the UART serializer.
REQ-008 snapshot_valid  output  1  snapshot_data is offered.
REQ-009 snapshot_ready  input  1  downstream accepts snapshot_data.
REQ-010 snapshot_seq  output  8  count of accepted snapshots, wrapping.

Function
REQ-011 Each bit SHALL pass through a 2-flop synchronizer; the stage-2 output is sync_bit.
REQ-012 Each bit SHALL have its own debounce counter; on any clock where sync_bit equals stable_bit, the counter resets to 0.
REQ-013 On a clock where sync_bit differs from stable_bit and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-014 On a clock where sync_bit differs from stable_bit and the counter equals DEBOUNCE_CYCLES-1, stable_bit SHALL take sync_bit and the counter SHALL return to 0.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave stable_bit unchanged.
REQ-016 The FSM SHALL have two states: IDLE (snapshot_valid=0) and OFFER (snapshot_valid=1).
REQ-017 In IDLE, if the stable word differs from last_sent, the block SHALL capture the stable word into snapshot_data and enter OFFER on the same edge.
REQ-018 In IDLE with the stable word equal to last_sent, HEARTBEAT_CYCLES nonzero, and the heartbeat counter equal to HEARTBEAT_CYCLES-1, the block SHALL capture the stable word and enter OFFER.
REQ-019 The heartbeat counter SHALL increment only in IDLE and SHALL clear on every capture.
REQ-020 In OFFER, snapshot_data SHALL remain constant until accepted; changes to the stable word during OFFER do not alter it.
REQ-021 A transfer SHALL occur on any edge where snapshot_valid and snapshot_ready are both 1.
REQ-022 On a transfer: last_sent takes snapshot_data, snapshot_seq increments (255 wraps to 0), and the state returns to IDLE.
REQ-023 Any stable-word change that occurs during OFFER SHALL be captured in IDLE on the clock after the transfer; intermediate states are coalesced.
REQ-024 snapshot_valid SHALL be a registered state output with no combinational dependence on snapshot_ready.
REQ-025 snapshot_ready=1 while in IDLE SHALL have no effect.
REQ-026 Latency: for an input change clean at edge k, stable_bit updates at edge k+1+DEBOUNCE_CYCLES and snapshot_valid rises at edge k+2+DEBOUNCE_CYCLES.
REQ-027 If two bits settle on different clocks while in IDLE, the first change SHALL be offered, and the second SHALL be offered after that transfer.

Reset
REQ-028 When reset_n=0 at an edge, the following SHALL become 0: synchronizer flops, stable word, debounce counters, last_sent, heartbeat counter, snapshot_data, snapshot_valid, snapshot_seq; the state SHALL become IDLE.
REQ-029 Reset asserted during OFFER SHALL drop snapshot_valid at that edge; the pending snapshot is discarded.
REQ-030 After reset with button_array=0 and HEARTBEAT_CYCLES=0, snapshot_valid SHALL stay 0 indefinitely.

Verification (DEBOUNCE_CYCLES=4, WIDTH=32)
REQ-031 Scenario: ready=1; button_array goes 0 to 0x00000001, clean at edge k -> snapshot_valid is 1 only after edge k+6, with data 0x00000001; it drops after edge k+7; snapshot_seq=1.
REQ-032 Scenario: bit 5 pulses high for 3 clocks, then low -> snapshot_valid never asserts and the stable word stays 0.
REQ-033 Scenario: ready=0; 0x0000000F is offered, then the input changes to 0x000000F0 -> data holds 0x0000000F until ready=1; after that transfer, valid re-asserts one clock later with 0x000000F0.
REQ-034 Scenario: HEARTBEAT_CYCLES=10; input constant at 0x12345678 after one transfer; ready=1 -> a re-offer of 0x12345678 arrives every 11 clocks (10 idle clocks plus 1 offer clock), and seq increments each time.
REQ-035 Scenario: 256 accepted transfers -> snapshot_seq wraps to 0.
REQ-036 Scenario: reset_n=0 for 1 clock during OFFER -> all outputs are 0 after that edge; with the input held at 0x00000001, a new offer appears 6 clocks after reset is released.
